score_display_driver: RTL and testbench

Downstream display stage for the ping-pong game. It takes the two players' 4-bit scores and drives a 4-digit multiplexed common-anode 7-segment display through two daisy-chained 74HC595 shift registers, using three pins: serial data, shift clock and latch clock. It scans one digit per frame, serialising a 16-bit word per frame, and repeats continuously.

---
 rtl/score_display_driver.sv | 162 ++++++++++++++++
 tb/tb_score_display_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/score_display_driver.sv
// score_display_driver
// Scans a 4-digit multiplexed common-anode 7-segment display through two
// daisy-chained 74HC595 shift registers. One digit is sent per frame as a
// 16-bit word {~seg, sel}, MSB first. A frame is LOAD, SHIFT (16 bits),
// LATCH and HOLD, and frames repeat continuously.
// Digit 0 shows score_2, digit 3 shows score_1, digits 1 and 2 are blank.

module score_display_driver #(
  parameter int CLK_DIV     = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score_1,
  input  logic [3:0] score_2,
  output logic       ser,
  output logic       sclk,
  output logic       rclk,
  output logic       frame_done
);

  // One counter serves the bit phases, the latch pulse and the hold time,
  // so it is sized for whichever of these is longest.
  localparam int CNT_MAX = (2 * CLK_DIV > HOLD_CYCLES) ? 2 * CLK_DIV : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [1:0]       dig;
  logic [14:0]      shreg;
  logic [15:0]      word_next;

  // Standard hex decode, active-high {dp,g,f,e,d,c,b,a}; dp is never lit.
  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    logic [7:0] seg;
    case (v)
      4'h0:    seg = 8'h3F;
      4'h1:    seg = 8'h06;
      4'h2:    seg = 8'h5B;
      4'h3:    seg = 8'h4F;
      4'h4:    seg = 8'h66;
      4'h5:    seg = 8'h6D;
      4'h6:    seg = 8'h7D;
      4'h7:    seg = 8'h07;
      4'h8:    seg = 8'h7F;
      4'h9:    seg = 8'h6F;
      4'hA:    seg = 8'h77;
      4'hB:    seg = 8'h7C;
      4'hC:    seg = 8'h39;
      4'hD:    seg = 8'h5E;
      4'hE:    seg = 8'h79;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

  // Frame word: segment byte is inverted for the common-anode drive, digit
  // select is an active-high one-hot. Blank digits light nothing (0xFF).
  function automatic logic [15:0] frame_word(input logic [1:0] d,
                                             input logic [3:0] s1,
                                             input logic [3:0] s2);
    logic [7:0] seg;
    logic [7:0] sel;
    case (d)
      2'd0:    seg = seg_decode(s2);
      2'd3:    seg = seg_decode(s1);
      default: seg = 8'h00;
    endcase
    sel = 8'h01 << d;
    return {~seg, sel};
  endfunction

  assign word_next = frame_word(dig, score_1, score_2);

  // Frame sequencer: owns all outputs, counters and the digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      cnt        <= '0;
      bit_idx    <= '0;
      dig        <= '0;
      ser        <= 1'b0;
      sclk       <= 1'b0;
      rclk       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // Scores are sampled only here; the first bit goes out with the
          // first low phase so it gets a full CLK_DIV of setup.
          ser     <= word_next[15];
          sclk    <= 1'b0;
          rclk    <= 1'b0;
          cnt     <= '0;
          bit_idx <= 4'd15;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (cnt == HALF_LAST) begin
            sclk <= 1'b1;
            cnt  <= cnt + 1'b1;
          end else if (cnt == BIT_LAST) begin
            sclk <= 1'b0;
            cnt  <= '0;
            if (bit_idx == 4'd0) begin
              rclk  <= 1'b1;
              state <= LATCH;
            end else begin
              // Next bit changes only now, CLK_DIV cycles after the rise.
              ser     <= shreg[14];
              bit_idx <= bit_idx - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LATCH: begin
          if (cnt == HALF_LAST) begin
            rclk       <= 1'b0;
            frame_done <= 1'b1;
            cnt        <= '0;
            state      <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          frame_done <= 1'b0;
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            dig   <= dig + 1'b1;
            state <= LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Remaining bits of the frame word; pure data, realigned by every LOAD.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      shreg <= word_next[14:0];
    end else if (state == SHIFT && cnt == BIT_LAST) begin
      shreg <= {shreg[13:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// Bench for score_display_driver with CLK_DIV=2, HOLD_CYCLES=8.
// Expected frame words are queued when scores are applied and checked when
// the DUT latches a word (rclk rise); a monitor also checks the serial
// protocol timing continuously.

module tb_score_display_driver;

  localparam int CLK_DIV     = 2;
  localparam int HOLD_CYCLES = 8;
  localparam int FRAME_LEN   = 1 + 32 * CLK_DIV + CLK_DIV + HOLD_CYCLES;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] score_1 = 4'd0;
  logic [3:0] score_2 = 4'd0;
  logic       ser, sclk, rclk, frame_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  int          exp_d = 0;
  logic [7:0]  hex_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // monitor state shared with the driver
  logic [15:0] shreg_m = 16'h0;
  logic [15:0] last_word = 16'h0;
  int          rise_cnt = 0;
  logic [7:0]  hex_hi [16];

  score_display_driver #(.CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .rst(rst), .score_1(score_1), .score_2(score_2),
    .ser(ser), .sclk(sclk), .rclk(rclk), .frame_done(frame_done)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_word(input int d, input logic [3:0] s1, input logic [3:0] s2);
    logic [7:0] seg;
    logic [7:0] sel;
    seg = (d == 0) ? hex_tbl[s2] : (d == 3) ? hex_tbl[s1] : 8'h00;
    sel = 8'h01 << d;
    return {~seg, sel};
  endfunction

  task automatic push_exp(input logic [3:0] s1, input logic [3:0] s2);
    exp_q.push_back(model_word(exp_d, s1, s2));
    exp_d = (exp_d + 1) % 4;
  endtask

  task automatic wait_fd();
    bit got = 1'b0;
    for (int i = 0; i < 4 * FRAME_LEN && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    if (!got) check("fd_timeout", got, 1);
  endtask

  // Apply scores for the frame about to load, then wait for its frame_done.
  task automatic run_frame(input logic [3:0] s1, input logic [3:0] s2);
    score_1 = s1;
    score_2 = s2;
    push_exp(s1, s2);
    wait_fd();
  endtask

  // Protocol monitor and scoreboard consumer, sampled on the falling edge.
  initial begin
    int  cyc = 0, first_rise = 0, last_fd = 0, rclk_hi = 0;
    int  since_ser = 100, since_rise = 100, rclk_since_fd = 0;
    bit  have_fd = 1'b0;
    logic p_ser = 1'b0, p_sclk = 1'b0, p_rclk = 1'b0, p_fd = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        p_ser = 1'b0; p_sclk = 1'b0; p_rclk = 1'b0; p_fd = 1'b0;
        since_ser = 100; since_rise = 100; rise_cnt = 0;
        rclk_since_fd = 0; have_fd = 1'b0; rclk_hi = 0;
      end else begin
        check("sclk_rclk_overlap", sclk & rclk, 0);
        since_rise++;
        if (ser !== p_ser) begin
          check("ser_hold", since_rise >= CLK_DIV, 1);
          since_ser = 0;
        end else begin
          since_ser++;
        end
        if (sclk && !p_sclk) begin
          check("ser_setup", since_ser >= CLK_DIV, 1);
          if (rise_cnt == 0) first_rise = cyc;
          shreg_m = {shreg_m[14:0], ser};
          rise_cnt++;
          since_rise = 0;
        end
        if (rclk) rclk_hi++;
        if (!rclk && p_rclk) begin
          check("rclk_width", rclk_hi, CLK_DIV);
          rclk_hi = 0;
        end
        if (rclk && !p_rclk) begin
          check("edges_per_latch", rise_cnt, 16);
          check("rclk_time", cyc - first_rise, 32 * CLK_DIV - CLK_DIV);
          if (exp_q.size() > 0) check("word", shreg_m, exp_q.pop_front());
          else check("sb_nonempty", exp_q.size(), 1);
          last_word = shreg_m;
          rise_cnt = 0;
          rclk_since_fd++;
        end
        if (frame_done) begin
          check("fd_width", p_fd, 0);
          check("fd_per_rclk", rclk_since_fd, 1);
          rclk_since_fd = 0;
          check("fd_time", cyc - first_rise, 32 * CLK_DIV);
          if (have_fd) check("frame_period", cyc - last_fd, FRAME_LEN);
          last_fd = cyc;
          have_fd = 1'b1;
        end
        p_ser = ser; p_sclk = sclk; p_rclk = rclk; p_fd = frame_done;
      end
    end
  end

  initial begin
    bit reached;

    // reset state
    score_1 = 4'd3;
    score_2 = 4'd7;
    repeat (3) @(negedge clk);
    check("rst_ser", ser, 0);
    check("rst_sclk", sclk, 0);
    check("rst_rclk", rclk, 0);
    check("rst_fd", frame_done, 0);

    // single frame and full scan with wrap
    push_exp(4'd3, 4'd7);
    @(negedge clk);
    rst = 1'b0;
    wait_fd();
    check("scan_w0", last_word, 16'hF801);
    run_frame(4'd3, 4'd7);
    check("scan_w1", last_word, 16'hFF02);
    run_frame(4'd3, 4'd7);
    check("scan_w2", last_word, 16'hFF04);
    run_frame(4'd3, 4'd7);
    check("scan_w3", last_word, 16'hB008);
    run_frame(4'd3, 4'd7);
    check("scan_wrap", last_word, 16'hF801);

    // hex decode sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      while (exp_d != 0) run_frame(4'd3, 4'(v));
      run_frame(4'd3, 4'(v));
      hex_hi[v] = last_word[15:8];
    end
    check("hex_0", hex_hi[0], 8'hC0);
    check("hex_9", hex_hi[9], 8'h90);
    check("hex_A", hex_hi[10], 8'h88);
    check("hex_F", hex_hi[15], 8'h8E);

    // score change while digit 0 is shifting
    while (exp_d != 0) run_frame(4'd3, 4'd7);
    score_1 = 4'd3;
    score_2 = 4'd7;
    push_exp(4'd3, 4'd7);
    repeat (20) @(negedge clk);
    score_2 = 4'd2;
    wait_fd();
    check("mid_cur", last_word, 16'hF801);
    while (exp_d != 0) run_frame(4'd3, 4'd2);
    run_frame(4'd3, 4'd2);
    check("mid_next", last_word, 16'hA401);

    // reset after the 5th sclk rise of a frame
    score_1 = 4'd3;
    score_2 = 4'd7;
    push_exp(4'd3, 4'd7);
    reached = 1'b0;
    for (int i = 0; i < 4 * FRAME_LEN && !reached; i++) begin
      @(negedge clk);
      #1;
      if (rise_cnt == 5) reached = 1'b1;
    end
    check("rst_mid_reach", reached, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {ser, sclk, rclk, frame_done}, 4'b0000);
    exp_q.delete();
    exp_d = 0;
    repeat (6) begin
      @(negedge clk);
      check("rst_mid_hold", {ser, sclk, rclk}, 3'b000);
    end
    push_exp(4'd3, 4'd7);
    rst = 1'b0;
    wait_fd();
    check("rst_mid_word", last_word, 16'hF801);

    // random scores, protocol monitor active throughout
    repeat (20) run_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
